elevator_button_encoder: RTL and testbench

Front-end stage for the elevator controller. Conditions 30 raw car/hall button lines, latches each debounced press as a pending request, and serialises pending requests one at a time onto the controller's 5-bit button code with a valid/ready handshake. It also produces the `move_dir` qualifier. The controller consumes `req_code` / `req_move_dir` directly.

---
 rtl/elevator_button_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_elevator_button_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_button_encoder.sv
// elevator_button_encoder
// Front-end for the elevator controller. It synchronises and debounces 30 raw
// button lines and latches each new press as a pending request. Pending requests
// are then issued one at a time, in round-robin order, over a valid/ready
// handshake as a 5-bit button code with a move-direction qualifier.
// Optional feature macro: ELEV_BTN_LAMP_EN builds the button lamp register.
// When the macro is not defined, lamp_o is tied low and the clear inputs are unused.

`timescale 1ns/1ps

module elevator_button_encoder #(
    parameter int DEB_DIV = 1000,
    parameter int DEB_CNT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  inside_btn_i,
    input  logic [9:0]  up_btn_i,
    input  logic [9:0]  down_btn_i,
    input  logic [3:0]  cur_floor_i,
    input  logic        req_ready_i,
    input  logic        clr_valid_i,
    input  logic [3:0]  clr_floor_i,
    output logic        req_valid_o,
    output logic [4:0]  req_code_o,
    output logic        req_move_dir_o,
    output logic [29:0] lamp_o
);

    localparam int N = 30;

    logic [N-1:0] rawBtn;
    logic [N-1:0] sync1_q, sync2_q;
    logic [15:0]  tickCnt_q, tickCnt_d;
    logic         tick;
    logic [3:0]   agreeCnt_q [N];
    logic [3:0]   agreeCnt_d [N];
    logic [N-1:0] debState_q, debState_d;
    logic [N-1:0] debPrev_q;
    logic [N-1:0] press;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] pickMask;
    logic [4:0]   last_q;
    logic         req_valid_q;
    logic [4:0]   req_code_q;
    logic         req_move_dir_q;
    logic         loadEn;
    logic         found;
    logic [4:0]   pickIdx;
    logic [5:0]   cand;
    logic         pickDir;

    // Request index order is inside 0..9, up 10..19, down 20..29.
    assign rawBtn = {down_btn_i, up_btn_i, inside_btn_i};

    // Two-flop synchroniser for the asynchronous button lines
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= rawBtn;
            sync2_q <= sync1_q;
        end
    end

    assign tick      = (tickCnt_q == 16'(DEB_DIV - 1));
    assign tickCnt_d = tick ? 16'd0 : tickCnt_q + 16'd1;

    // Per-button agreement counting; state flips after DEB_CNT differing ticks
    always_comb begin
        debState_d = debState_q;
        for (int j = 0; j < N; j++) begin
            agreeCnt_d[j] = agreeCnt_q[j];
            if (tick) begin
                if (sync2_q[j] != debState_q[j]) begin
                    if (agreeCnt_q[j] == 4'(DEB_CNT - 1)) begin
                        debState_d[j] = ~debState_q[j];
                        agreeCnt_d[j] = 4'd0;
                    end else begin
                        agreeCnt_d[j] = agreeCnt_q[j] + 4'd1;
                    end
                end else begin
                    agreeCnt_d[j] = 4'd0;
                end
            end
        end
    end

    // Sample-tick divider and debounce state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tickCnt_q  <= '0;
            debState_q <= '0;
            debPrev_q  <= '0;
            for (int j = 0; j < N; j++) begin
                agreeCnt_q[j] <= '0;
            end
        end else begin
            tickCnt_q  <= tickCnt_d;
            debState_q <= debState_d;
            debPrev_q  <= debState_q;
            for (int j = 0; j < N; j++) begin
                agreeCnt_q[j] <= agreeCnt_d[j];
            end
        end
    end

    // Only the rising edge of the debounced state counts as a press.
    assign press  = debState_q & ~debPrev_q;
    assign loadEn = !req_valid_q || req_ready_i;

    // Round-robin search for the first pending index after the last one issued
    always_comb begin
        found   = 1'b0;
        pickIdx = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = 6'(last_q) + 6'(k) + 6'd1;
            if (cand >= 6'd30) begin
                cand = cand - 6'd30;
            end
            if (!found && pending_q[cand[4:0]]) begin
                found   = 1'b1;
                pickIdx = cand[4:0];
            end
        end
    end

    // Direction: inside calls compare against the car floor, hall calls are fixed
    always_comb begin
        pickDir = 1'b0;
        if (pickIdx < 5'd10) begin
            pickDir = (pickIdx > {1'b0, cur_floor_i});
        end else if (pickIdx < 5'd20) begin
            pickDir = 1'b1;
        end
    end

    // A press arriving on the bit being issued wins, so that request is reissued later.
    assign pickMask  = (loadEn && found) ? (N'(1) << pickIdx) : '0;
    assign pending_d = (pending_q & ~pickMask) | press;

    // Pending request set and the handshake output register
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q      <= '0;
            last_q         <= 5'd29;
            req_valid_q    <= 1'b0;
            req_code_q     <= '0;
            req_move_dir_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (loadEn) begin
                if (found) begin
                    req_valid_q    <= 1'b1;
                    req_code_q     <= pickIdx + 5'd1;
                    req_move_dir_q <= pickDir;
                    last_q         <= pickIdx;
                end else begin
                    req_valid_q    <= 1'b0;
                    req_code_q     <= '0;
                    req_move_dir_q <= 1'b0;
                end
            end
        end
    end

    assign req_valid_o    = req_valid_q;
    assign req_code_o     = req_code_q;
    assign req_move_dir_o = req_move_dir_q;

`ifdef ELEV_BTN_LAMP_EN
    logic [N-1:0] lamp_q;
    logic [N-1:0] pressDly_q;
    logic [9:0]   floorHot;
    logic [N-1:0] clrMask;

    // A floor clear covers the car, hall-up and hall-down lamps of that floor.
    assign floorHot = 10'd1 << clr_floor_i;
    assign clrMask  = (clr_valid_i && (clr_floor_i <= 4'd9)) ?
                      {floorHot, floorHot, floorHot} : '0;

    // Lamps follow pending by one cycle; a new press overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pressDly_q <= '0;
            lamp_q     <= '0;
        end else begin
            pressDly_q <= press;
            lamp_q     <= (lamp_q & ~clrMask) | pressDly_q;
        end
    end

    assign lamp_o = lamp_q;
`else
    logic unusedClr;

    assign unusedClr = clr_valid_i ^ (^clr_floor_i);
    assign lamp_o    = '0;
`endif

endmodule

// File: tb/tb_elevator_button_encoder.sv
// tb_elevator_button_encoder
// Directed bench for elevator_button_encoder with DEB_DIV=4 and DEB_CNT=3.
// A table of single-button presses checks codes and directions. Hand-written
// sequences cover glitch rejection, backpressure, mid-run reset, round-robin
// order and, when ELEV_BTN_LAMP_EN is defined, the lamp set/clear behaviour.

`timescale 1ns/1ps

module tb_elevator_button_encoder;

    localparam int DEB_DIV = 4;
    localparam int DEB_CNT = 3;

    typedef struct {
        int idx;
        int floor;
        int expCode;
        int expDir;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] rawBtn;
    logic [3:0]  curFloor;
    logic        reqReady;
    logic        clrValid;
    logic [3:0]  clrFloor;
    logic        reqValid;
    logic [4:0]  reqCode;
    logic        reqMoveDir;
    logic [29:0] lamp;

    int checks   = 0;
    int failures = 0;
    int xferCode[$];
    int xferDir[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    elevator_button_encoder #(
        .DEB_DIV(DEB_DIV),
        .DEB_CNT(DEB_CNT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inside_btn_i   (rawBtn[9:0]),
        .up_btn_i       (rawBtn[19:10]),
        .down_btn_i     (rawBtn[29:20]),
        .cur_floor_i    (curFloor),
        .req_ready_i    (reqReady),
        .clr_valid_i    (clrValid),
        .clr_floor_i    (clrFloor),
        .req_valid_o    (reqValid),
        .req_code_o     (reqCode),
        .req_move_dir_o (reqMoveDir),
        .lamp_o         (lamp)
    );

    // Record every handshake transfer, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset && reqValid && reqReady) begin
            xferCode.push_back(int'(reqCode));
            xferDir.push_back(int'(reqMoveDir));
        end
    end

    // Safety net so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [29:0] mask, input int holdCycles, input int settleCycles);
        rawBtn = rawBtn | mask;
        waitCycles(holdCycles);
        rawBtn = rawBtn & ~mask;
        waitCycles(settleCycles);
    endtask

    task automatic waitValid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (reqValid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int xferAt(input int n);
        return (xferCode.size() > n) ? xferCode[n] : -1;
    endfunction

    function automatic int dirAt(input int n);
        return (xferDir.size() > n) ? xferDir[n] : -1;
    endfunction

    initial begin
        bit ok;
        int stable;

        rawBtn   = '0;
        curFloor = '0;
        reqReady = 1'b0;
        clrValid = 1'b0;
        clrFloor = '0;
        reset    = 1'b1;

        // Last entry must be inside floor 0 so the backpressure test starts after index 0.
        vecs[0] = '{2,  5, 3,  0};
        vecs[1] = '{8,  5, 9,  1};
        vecs[2] = '{5,  5, 6,  0};
        vecs[3] = '{9,  0, 10, 1};
        vecs[4] = '{10, 9, 11, 1};
        vecs[5] = '{29, 0, 30, 0};
        vecs[6] = '{20, 3, 21, 0};
        vecs[7] = '{0,  0, 1,  0};

        waitCycles(3);
        @(negedge clk);
        checkOutput("reset_valid", int'(reqValid), 0);
        checkOutput("reset_code", int'(reqCode), 0);
        checkOutput("reset_dir", int'(reqMoveDir), 0);
        checkOutput("reset_lamp", int'(lamp != '0), 0);
        waitCycles(1);
        reset = 1'b0;

        // Glitch filter: a 5-cycle pulse is too short, a 20-cycle hold is one press
        reqReady = 1'b1;
        xferCode.delete();
        xferDir.delete();
        applyStimulus(30'd1 << 13, 5, 30);
        checkOutput("glitch_no_xfer", xferCode.size(), 0);
        applyStimulus(30'd1 << 13, 20, 30);
        checkOutput("hold_xfer_count", xferCode.size(), 1);
        checkOutput("hold_code", xferAt(0), 14);
        checkOutput("hold_dir", dirAt(0), 1);

        // Table of single presses
        for (int i = 0; i < 8; i++) begin
            xferCode.delete();
            xferDir.delete();
            curFloor = 4'(vecs[i].floor);
            applyStimulus(30'd1 << vecs[i].idx, 20, 30);
            checkOutput($sformatf("vec%0d_count", i), xferCode.size(), 1);
            checkOutput($sformatf("vec%0d_code", i), xferAt(0), vecs[i].expCode);
            checkOutput($sformatf("vec%0d_dir", i), dirAt(0), vecs[i].expDir);
        end

        // Backpressure: down 7 and inside 0 together, output held until ready
        reqReady = 1'b0;
        xferCode.delete();
        xferDir.delete();
        applyStimulus((30'd1 << 27) | (30'd1 << 0), 20, 5);
        waitValid(20, ok);
        checkOutput("bp_valid_seen", int'(ok), 1);
        checkOutput("bp_first_code", int'(reqCode), 28);
        checkOutput("bp_first_dir", int'(reqMoveDir), 0);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (reqValid && reqCode == 5'd28) stable++;
        end
        checkOutput("bp_hold_stable", stable, 10);
        waitCycles(1);
        reqReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_xfer1_code", int'(reqCode), 28);
        waitCycles(1);
        @(negedge clk);
        checkOutput("bp_xfer2_valid", int'(reqValid), 1);
        checkOutput("bp_xfer2_code", int'(reqCode), 1);
        waitCycles(1);
        @(negedge clk);
        checkOutput("bp_idle_valid", int'(reqValid), 0);
        checkOutput("bp_xfer_count", xferCode.size(), 2);
        checkOutput("bp_order0", xferAt(0), 28);
        checkOutput("bp_order1", xferAt(1), 1);

        // Reset in the middle of a backlog
        waitCycles(1);
        reqReady = 1'b0;
        applyStimulus((30'd1 << 3) | (30'd1 << 12) | (30'd1 << 25), 20, 5);
        waitValid(20, ok);
        checkOutput("rst_valid_before", int'(ok), 1);
        xferCode.delete();
        xferDir.delete();
        waitCycles(1);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", int'(reqValid), 0);
        checkOutput("rst_code", int'(reqCode), 0);
        checkOutput("rst_dir", int'(reqMoveDir), 0);
        checkOutput("rst_lamp", int'(lamp != '0), 0);
        waitCycles(1);
        reqReady = 1'b1;
        waitCycles(40);
        checkOutput("rst_no_xfer", xferCode.size(), 0);

        // Round robin over indices 0, 15, 29 with index 0 re-pressed
        reqReady = 1'b0;
        xferCode.delete();
        xferDir.delete();
        applyStimulus((30'd1 << 0) | (30'd1 << 15) | (30'd1 << 29), 20, 30);
        waitValid(5, ok);
        checkOutput("rr_valid", int'(ok), 1);
        checkOutput("rr_head_code", int'(reqCode), 1);
        waitCycles(1);
        applyStimulus(30'd1 << 0, 20, 30);
        reqReady = 1'b1;
        waitCycles(8);
        checkOutput("rr_count", xferCode.size(), 4);
        checkOutput("rr_order0", xferAt(0), 1);
        checkOutput("rr_order1", xferAt(1), 16);
        checkOutput("rr_order2", xferAt(2), 30);
        checkOutput("rr_order3", xferAt(3), 1);

        // Lamp behaviour for up floor 4
        reqReady = 1'b1;
        xferCode.delete();
        xferDir.delete();
        applyStimulus(30'd1 << 14, 20, 30);
        checkOutput("lamp_xfer_code", xferAt(0), 15);
`ifdef ELEV_BTN_LAMP_EN
        checkOutput("lamp_on_after_xfer", int'(lamp[14]), 1);
        clrFloor = 4'd12;
        clrValid = 1'b1;
        waitCycles(1);
        clrValid = 1'b0;
        @(negedge clk);
        checkOutput("lamp_clr_out_of_range", int'(lamp[14]), 1);
        waitCycles(1);
        clrFloor = 4'd4;
        clrValid = 1'b1;
        waitCycles(1);
        clrValid = 1'b0;
        @(negedge clk);
        checkOutput("lamp_cleared", int'(lamp[14]), 0);
`else
        checkOutput("lamp_tied_low", int'(lamp != '0), 0);
        clrFloor = 4'd4;
        clrValid = 1'b1;
        waitCycles(1);
        clrValid = 1'b0;
        @(negedge clk);
        checkOutput("lamp_tied_low_after_clr", int'(lamp != '0), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
